// File: rtl/vga_timing_gen.sv
// vga_timing_gen: generic VGA raster timing generator with a two-stage
// pixel pipeline (request stage A, output stage B) and built-in patterns.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int COLOR_W  = 3,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] pixelIn,
    output logic               reqValid,
    output logic [X_W-1:0]     reqX,
    output logic [Y_W-1:0]     reqY,
    output logic               hSync,
    output logic               vSync,
    output logic               de,
    output logic [COLOR_W-1:0] color,
    output logic               frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int REP     = COLOR_W / 3;
    localparam int RUN_LEN = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE    = DIV_W'(1);
    localparam logic [X_W-1:0]   X_ONE      = X_W'(1);
    localparam logic [Y_W-1:0]   Y_ONE      = Y_W'(1);
    localparam logic [X_W-1:0]   H_LAST     = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]   H_ACT_END  = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]   H_SYNC_BEG = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   H_SYNC_END = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0]   V_LAST     = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_ACT_END  = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0]   V_SYNC_BEG = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   V_SYNC_END = Y_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [X_W-1:0]   RUN_LAST   = X_W'(RUN_LEN - 1);

    logic [DIV_W-1:0]   divCnt_q, divCnt_d;
    logic [X_W-1:0]     hCnt_q, hCnt_d;
    logic [Y_W-1:0]     vCnt_q, vCnt_d;
    logic               reqValid_q, reqValid_d;
    logic [X_W-1:0]     reqX_q, reqX_d;
    logic [Y_W-1:0]     reqY_q, reqY_d;
    logic               hSyncA_q, hSyncA_d;
    logic               vSyncA_q, vSyncA_d;
    logic [2:0]         barCnt_q, barCnt_d;
    logic [X_W-1:0]     runCnt_q, runCnt_d;
    logic [1:0]         modeReg_q, modeReg_d;
    logic               hSync_q, hSync_d;
    logic               vSync_q, vSync_d;
    logic               de_q, de_d;
    logic [COLOR_W-1:0] color_q, color_d;
    logic               startPend_q, startPend_d;
    logic               frameStart_q, frameStart_d;

    logic               tick;
    logic               visA;
    logic               originA;
    logic               hInSync;
    logic               vInSync;
    logic [COLOR_W-1:0] src;

    assign tick    = (divCnt_q == DIV_LAST);
    assign visA    = (hCnt_q < H_ACT_END) && (vCnt_q < V_ACT_END);
    assign originA = (hCnt_q == '0) && (vCnt_q == '0);
    assign hInSync = (hCnt_q >= H_SYNC_BEG) && (hCnt_q < H_SYNC_END);
    assign vInSync = (vCnt_q >= V_SYNC_BEG) && (vCnt_q < V_SYNC_END);

    // Pixel-tick divider and raster counters; the line counter steps when the pixel counter wraps.
    always_comb begin
        divCnt_d = tick ? '0 : divCnt_q + DIV_ONE;
        hCnt_d   = hCnt_q;
        vCnt_d   = vCnt_q;
        if (tick) begin
            if (hCnt_q == H_LAST) begin
                hCnt_d = '0;
                vCnt_d = (vCnt_q == V_LAST) ? '0 : vCnt_q + Y_ONE;
            end else begin
                hCnt_d = hCnt_q + X_ONE;
            end
        end
    end

    // Stage A: request coordinates, raw syncs, bar position and the per-frame mode latch.
    always_comb begin
        reqValid_d  = reqValid_q;
        reqX_d      = reqX_q;
        reqY_d      = reqY_q;
        hSyncA_d    = hSyncA_q;
        vSyncA_d    = vSyncA_q;
        barCnt_d    = barCnt_q;
        runCnt_d    = runCnt_q;
        modeReg_d   = modeReg_q;
        startPend_d = tick && originA;
        if (tick) begin
            reqValid_d = visA;
            hSyncA_d   = hInSync ? H_POL : ~H_POL;
            vSyncA_d   = vInSync ? V_POL : ~V_POL;
            if (visA) begin
                reqX_d = hCnt_q;
                reqY_d = vCnt_q;
                if (hCnt_q == '0) begin
                    barCnt_d = 3'd0;
                    runCnt_d = '0;
                end else if (runCnt_q == RUN_LAST) begin
                    barCnt_d = barCnt_q + 3'd1;
                    runCnt_d = '0;
                end else begin
                    runCnt_d = runCnt_q + X_ONE;
                end
            end
            if (originA) begin
                modeReg_d = mode;
            end
        end
    end

    // Pixel source for the coordinate currently held in stage A.
    always_comb begin
        src = '0;
        unique case (modeReg_q)
            2'b00:   src = pixelIn;
            2'b01:   src = {{REP{barCnt_q[2]}}, {REP{barCnt_q[1]}}, {REP{barCnt_q[0]}}};
            2'b10:   src = (reqX_q[4] ^ reqY_q[4]) ? {COLOR_W{1'b1}} : {COLOR_W{1'b0}};
            default: src = {COLOR_W{1'b1}};
        endcase
    end

    // Stage B: pin-facing registers, colour forced to zero outside the visible area.
    always_comb begin
        hSync_d      = hSync_q;
        vSync_d      = vSync_q;
        de_d         = de_q;
        color_d      = color_q;
        frameStart_d = startPend_q;
        if (tick) begin
            hSync_d = hSyncA_q;
            vSync_d = vSyncA_q;
            de_d    = reqValid_q;
            color_d = reqValid_q ? src : '0;
        end
    end

    // All state registers share one asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            divCnt_q     <= '0;
            hCnt_q       <= '0;
            vCnt_q       <= '0;
            reqValid_q   <= 1'b0;
            reqX_q       <= '0;
            reqY_q       <= '0;
            hSyncA_q     <= ~H_POL;
            vSyncA_q     <= ~V_POL;
            barCnt_q     <= 3'd0;
            runCnt_q     <= '0;
            modeReg_q    <= 2'b00;
            hSync_q      <= ~H_POL;
            vSync_q      <= ~V_POL;
            de_q         <= 1'b0;
            color_q      <= '0;
            startPend_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            divCnt_q     <= divCnt_d;
            hCnt_q       <= hCnt_d;
            vCnt_q       <= vCnt_d;
            reqValid_q   <= reqValid_d;
            reqX_q       <= reqX_d;
            reqY_q       <= reqY_d;
            hSyncA_q     <= hSyncA_d;
            vSyncA_q     <= vSyncA_d;
            barCnt_q     <= barCnt_d;
            runCnt_q     <= runCnt_d;
            modeReg_q    <= modeReg_d;
            hSync_q      <= hSync_d;
            vSync_q      <= vSync_d;
            de_q         <= de_d;
            color_q      <= color_d;
            startPend_q  <= startPend_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign reqValid   = reqValid_q;
    assign reqX       = reqX_q;
    assign reqY       = reqY_q;
    assign hSync      = hSync_q;
    assign vSync      = vSync_q;
    assign de         = de_q;
    assign color      = color_q;
    assign frameStart = frameStart_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three configurations of the timing generator, exercised one
// at a time (the others held in reset) against a raster-position scoreboard.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [2:0] col;
    } pins_t;

    logic       clk;
    logic       rstD, rstM, rstS;
    logic [1:0] mode;
    logic [2:0] pixelIn;

    logic       rvD, rvM, rvS;
    logic [9:0] rxD, rxM, rxS, ryD, ryM, ryS;
    logic       hsD, hsM, hsS, vsD, vsM, vsS;
    logic       deD, deM, deS, fsD, fsM, fsS;
    logic [2:0] colD, colM, colS;

    int         sel;
    logic       oRv, oHs, oVs, oDe, oFs;
    logic [9:0] oRx, oRy;
    logic [2:0] oCol;

    int         testsRun;
    int         failCount;

    int         cHA, cHFP, cHS, cHBP, cVA, cVFP, cVS, cVBP, cDiv;
    bit         cHPol, cVPol;
    int         hTot, vTot, frameLen;

    pins_t      sbq[$];
    int         edgeCnt;
    bit         lastOrigin;
    logic [1:0] frameMode;
    logic [9:0] lastX, lastY;
    int         hsOn1, hsOff1, hsOn2, vsOn1, vsOff1, vsOn2, deInLine;
    logic       prevHs, prevVs;

    // Default configuration: 640x480, divide-by-two pixel clock.
    vga_timing_gen dutD (
        .clk(clk), .rst(rstD), .mode(mode), .pixelIn(pixelIn),
        .reqValid(rvD), .reqX(rxD), .reqY(ryD), .hSync(hsD), .vSync(vsD),
        .de(deD), .color(colD), .frameStart(fsD)
    );

    // Medium raster, short enough to run whole frames, wide enough for the checkerboard.
    vga_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(40), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(2)
    ) dutM (
        .clk(clk), .rst(rstM), .mode(mode), .pixelIn(pixelIn),
        .reqValid(rvM), .reqX(rxM), .reqY(ryM), .hSync(hsM), .vSync(vsM),
        .de(deM), .color(colM), .frameStart(fsM)
    );

    // Tiny raster with undivided clock and positive hSync.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .H_POL(1'b1), .CLK_DIV(1)
    ) dutS (
        .clk(clk), .rst(rstS), .mode(mode), .pixelIn(pixelIn),
        .reqValid(rvS), .reqX(rxS), .reqY(ryS), .hSync(hsS), .vSync(vsS),
        .de(deS), .color(colS), .frameStart(fsS)
    );

    // Free-running 100 MHz bench clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Route the outputs of whichever instance is under test to one set of observation nets.
    always_comb begin
        oRv  = rvD;  oRx = rxD;  oRy = ryD;  oHs = hsD;  oVs = vsD;
        oDe  = deD;  oCol = colD; oFs = fsD;
        case (sel)
            1: begin
                oRv = rvM; oRx = rxM; oRy = ryM; oHs = hsM; oVs = vsM;
                oDe = deM; oCol = colM; oFs = fsM;
            end
            2: begin
                oRv = rvS; oRx = rxS; oRy = ryS; oHs = hsS; oVs = vsS;
                oDe = deS; oCol = colS; oFs = fsS;
            end
            default: ;
        endcase
    end

    // One comparison: counts it, and on mismatch counts the failure and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Load the model's copy of the raster geometry for the instance under test.
    task automatic setCfg(input int s);
        sel = s;
        case (s)
            1: begin
                cHA = 64; cHFP = 4; cHS = 8; cHBP = 4;
                cVA = 40; cVFP = 2; cVS = 2; cVBP = 2;
                cDiv = 2; cHPol = 1'b0; cVPol = 1'b0;
            end
            2: begin
                cHA = 8; cHFP = 1; cHS = 2; cHBP = 1;
                cVA = 4; cVFP = 1; cVS = 1; cVBP = 1;
                cDiv = 1; cHPol = 1'b1; cVPol = 1'b0;
            end
            default: begin
                cHA = 640; cHFP = 16; cHS = 96; cHBP = 48;
                cVA = 480; cVFP = 10; cVS = 2; cVBP = 33;
                cDiv = 2; cHPol = 1'b0; cVPol = 1'b0;
            end
        endcase
        hTot     = cHA + cHFP + cHS + cHBP;
        vTot     = cVA + cVFP + cVS + cVBP;
        frameLen = hTot * vTot;
    endtask

    // Expected pin values for raster position p, from the geometry and the frame's mode.
    function automatic pins_t expectPins(input int p);
        pins_t r;
        int    h;
        int    v;
        bit    vis;
        h     = p % hTot;
        v     = (p / hTot) % vTot;
        vis   = (h < cHA) && (v < cVA);
        r.hs  = ((h >= cHA + cHFP) && (h < cHA + cHFP + cHS)) ? cHPol : ~cHPol;
        r.vs  = ((v >= cVA + cVFP) && (v < cVA + cVFP + cVS)) ? cVPol : ~cVPol;
        r.de  = vis;
        r.col = 3'd0;
        if (vis) begin
            case (frameMode)
                2'b00:   r.col = 3'(h % 8);
                2'b01:   r.col = 3'(h / (cHA / 8));
                2'b10:   r.col = (((h / 16) % 2) != ((v / 16) % 2)) ? 3'd7 : 3'd0;
                default: r.col = 3'd7;
            endcase
        end
        return r;
    endfunction

    // Every output must sit at its reset value while reset is asserted.
    task automatic checkReset(input string who);
        logic hsIdle;
        logic vsIdle;
        hsIdle = ~cHPol;
        vsIdle = ~cVPol;
        checkOutput({who, ".rst.hSync"}, 32'(oHs), 32'(hsIdle));
        checkOutput({who, ".rst.vSync"}, 32'(oVs), 32'(vsIdle));
        checkOutput({who, ".rst.de"}, 32'(oDe), 32'd0);
        checkOutput({who, ".rst.color"}, 32'(oCol), 32'd0);
        checkOutput({who, ".rst.reqValid"}, 32'(oRv), 32'd0);
        checkOutput({who, ".rst.reqX"}, 32'(oRx), 32'd0);
        checkOutput({who, ".rst.reqY"}, 32'(oRy), 32'd0);
        checkOutput({who, ".rst.frameStart"}, 32'(oFs), 32'd0);
    endtask

    // Clear scoreboard and measurement state at a reset release.
    task automatic startRun();
        sbq.delete();
        edgeCnt    = 0;
        lastOrigin = 1'b0;
        frameMode  = 2'b00;
        lastX      = 10'd0;
        lastY      = 10'd0;
        hsOn1 = -1; hsOff1 = -1; hsOn2 = -1;
        vsOn1 = -1; vsOff1 = -1; vsOn2 = -1;
        deInLine = 0;
        prevHs   = oHs;
        prevVs   = oVs;
        pixelIn  = 3'd0;
    endtask

    // Advance one clk: push the expectation for the position entering stage A on a tick,
    // pop the one two ticks old against the pins, and answer the pixel request.
    task automatic stepOne();
        int    p;
        int    h;
        int    v;
        bit    vis;
        pins_t got;
        pins_t want;
        @(posedge clk);
        #1;
        edgeCnt++;
        checkOutput("frameStart", 32'(oFs), 32'(lastOrigin));
        lastOrigin = 1'b0;
        if ((edgeCnt % cDiv) == 0) begin
            p   = edgeCnt / cDiv - 1;
            h   = p % hTot;
            v   = (p / hTot) % vTot;
            vis = (h < cHA) && (v < cVA);
            if ((p % frameLen) == 0) begin
                frameMode  = mode;
                lastOrigin = 1'b1;
            end
            sbq.push_back(expectPins(p));
            if (vis) begin
                lastX = 10'(h);
                lastY = 10'(v);
            end
            checkOutput("reqValid", 32'(oRv), 32'(vis));
            checkOutput("reqX", 32'(oRx), 32'(lastX));
            checkOutput("reqY", 32'(oRy), 32'(lastY));
            if (sbq.size() >= 2) begin
                want = sbq.pop_front();
                got  = {oHs, oVs, oDe, oCol};
                checkOutput("pins{hs,vs,de,col}", 32'(got), 32'(want));
            end
        end
        if (oHs !== prevHs) begin
            if (oHs === cHPol) begin
                if (hsOn1 < 0) hsOn1 = edgeCnt;
                else if (hsOn2 < 0) hsOn2 = edgeCnt;
            end else if (hsOff1 < 0) begin
                hsOff1 = edgeCnt;
            end
            prevHs = oHs;
        end
        if (oVs !== prevVs) begin
            if (oVs === cVPol) begin
                if (vsOn1 < 0) vsOn1 = edgeCnt;
                else if (vsOn2 < 0) vsOn2 = edgeCnt;
            end else if (vsOff1 < 0) begin
                vsOff1 = edgeCnt;
            end
            prevVs = oVs;
        end
        if ((hsOn1 >= 0) && (hsOn2 < 0) && (oDe === 1'b1)) deInLine++;
        pixelIn = oRx[2:0];
    endtask

    // Run the scoreboard for a fixed number of clks.
    task automatic applyStimulus(input int nClks);
        for (int i = 0; i < nClks; i++) begin
            stepOne();
        end
    endtask

    // Directed sequence: default raster, medium raster with a mid-frame mode change,
    // tiny raster with a mid-line reset and restart.
    initial begin
        testsRun  = 0;
        failCount = 0;
        rstD      = 1'b0;
        rstM      = 1'b0;
        rstS      = 1'b0;
        mode      = 2'b01;
        pixelIn   = 3'd0;
        setCfg(0);

        repeat (5) @(negedge clk);
        checkReset("D");
        rstD = 1'b1;
        startRun();
        applyStimulus(5000);
        checkOutput("D.hsOn1", 32'(hsOn1), 32'd1316);
        checkOutput("D.hsWidth", 32'(hsOff1 - hsOn1), 32'd192);
        checkOutput("D.hsPeriod", 32'(hsOn2 - hsOn1), 32'd1600);
        checkOutput("D.deClksPerLine", 32'(deInLine), 32'd1280);
        @(negedge clk);
        rstD = 1'b0;

        setCfg(1);
        mode = 2'b01;
        repeat (3) @(negedge clk);
        checkReset("M");
        rstM = 1'b1;
        startRun();
        applyStimulus(3200);
        mode = 2'b10;
        applyStimulus(11920);
        checkOutput("M.vsOn1", 32'(vsOn1), 32'd6724);
        checkOutput("M.vsWidth", 32'(vsOff1 - vsOn1), 32'd320);
        checkOutput("M.vsPeriod", 32'(vsOn2 - vsOn1), 32'd7360);
        checkOutput("M.deClksPerLine", 32'(deInLine), 32'd128);
        @(negedge clk);
        rstM = 1'b0;

        setCfg(2);
        mode = 2'b00;
        repeat (3) @(negedge clk);
        checkReset("S");
        rstS = 1'b1;
        startRun();
        applyStimulus(114);
        checkOutput("S.hsOn1", 32'(hsOn1), 32'd11);
        checkOutput("S.hsWidth", 32'(hsOff1 - hsOn1), 32'd2);
        checkOutput("S.hsPeriod", 32'(hsOn2 - hsOn1), 32'd12);
        checkOutput("S.deClksPerLine", 32'(deInLine), 32'd8);
        @(negedge clk);
        rstS = 1'b0;
        #1;
        checkReset("S.mid");
        repeat (2) @(negedge clk);
        mode = 2'b11;
        @(negedge clk);
        rstS = 1'b1;
        startRun();
        applyStimulus(180);
        checkOutput("S2.hsOn1", 32'(hsOn1), 32'd11);
        checkOutput("S2.hsWidth", 32'(hsOff1 - hsOn1), 32'd2);
        checkOutput("S2.hsPeriod", 32'(hsOn2 - hsOn1), 32'd12);
        checkOutput("S2.vsOn1", 32'(vsOn1), 32'd62);
        checkOutput("S2.vsPeriod", 32'(vsOn2 - vsOn1), 32'd84);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and pixel pipeline that drives the `hSync`, `vSync` and `color` pins of the VGA connector. It replaces the fixed 640x480 controller with fully generic porch, sync and active lengths, sync polarities, a pixel-clock divider and colour width. It adds a one-tick-ahead pixel request interface for an external frame source, and built-in test patterns selected per frame.

## Interface
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch, pixels
- `H_SYNC`, 96: horizontal sync width, pixels
- `H_BP`, 48: horizontal back porch, pixels
- `V_ACTIVE`, 480: visible lines
- `V_FP`, 10: vertical front porch, lines
- `V_SYNC`, 2: vertical sync width, lines
- `V_BP`, 33: vertical back porch, lines
- `H_POL`, 0: hSync active level
- `V_POL`, 0: vSync active level
- `CLK_DIV`, 2: clk cycles per pixel, ≥1
- `COLOR_W`, 3: colour bits, multiple of 3
- `X_W`, 10 / `Y_W`, 10: counter widths, must hold totals−1
- `clk` in 1: system clock (50 MHz nominal)
- `rst` in 1: asynchronous, active-low reset
- `mode` in 2: source select. 00 external, 01 colour bars, 10 checkerboard, 11 solid white
- `pixelIn` in COLOR_W: external pixel for the previously requested coordinate
- `reqValid` out 1: `reqX`/`reqY` name a visible pixel
- `reqX` out X_W: requested column
- `reqY` out Y_W: requested row
- `hSync` out 1: horizontal sync
- `vSync` out 1: vertical sync
- `de` out 1: `color` is a visible pixel
- `color` out COLOR_W: pixel output, 0 when `de`=0
- `frameStart` out 1: one-clk pulse at start of each frame

## Operation
- Pixel tick: `divCnt` counts 0..CLK_DIV−1 and the tick fires when `divCnt`==CLK_DIV−1. With CLK_DIV=1 the tick fires every clk. All stages advance only on a tick.
- Counters: `hCnt` 0..H_TOTAL−1, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP. It wraps to 0 and `vCnt` increments; `vCnt` wraps to 0 after V_TOTAL−1.
- Line order: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical order is the same.
- hSync runs on every line, including vertical blanking.
- Stage A (request) is registered from the counters:
  - `reqValid` = hCnt<H_ACTIVE && vCnt<V_ACTIVE
  - `reqX`/`reqY` = counters when valid, else held
  - internal hSyncA/vSyncA
- Stage B (output), on the next tick:
  - `hSync`/`vSync` ← A, driven at the active level during sync
  - `de` ← `reqValid`
  - `color` ← source if `reqValid`, else 0
- External mode: `pixelIn` is sampled on the tick that loads stage B. The source has exactly one pixel tick to answer a request.
- Colour bars: `barCnt` 0..7. It resets when reqX==0 and advances every H_ACTIVE/8 pixels using an internal run counter; no divider. Colour = each bar bit replicated COLOR_W/3 times.
- Checkerboard: all-ones if reqX[4]^reqY[4], else 0.
- Mode latch: `modeReg` samples `mode` only on the tick that loads (0,0) into stage A. A mid-frame change takes effect at the next frame.
- `frameStart` is high for the single clk following the tick that loads stage A with (0,0).

## Timing
- Reset (async, rst=0) values:
  - `divCnt`, `hCnt`, `vCnt` = 0
  - `hSync`=~H_POL, `vSync`=~V_POL
  - `de`, `color`, `reqValid`, `reqX`, `reqY`, `frameStart` = 0
  - `modeReg` = 00
- After reset release, raster position P=vCnt·H_TOTAL+hCnt reaches the pins on tick P+2. Pipeline latency is 2 pixel ticks.
- Defaults, counting clk rising edges after rst rises:
  - first tick at edge 2
  - first hSync low at edge 1316, low for 192 clks, period 1600
  - vSync low at edge 784004, low for 3200 clks, period 840000
- First `frameStart` on edge 3. `modeReg` is latched at edge 2 from `mode`.
- Reset asserted mid-frame: all outputs take reset values immediately. On release, timing is identical to power-up.

## Test plan
- rst low 5 clks with mode=01 → hSync=1, vSync=0→1 per polarity (1), color=0, de=0, reqValid=0, frameStart=0.
- Default params, 2 frames → hSync falls at edge 1316, width 192, period 1600; vSync falls at 784004, width 3200, period 840000; de high 1280 clks per visible line, 480 lines.
- mode=01 → line 0 color=0 for 160 clks, then 1,2..7 each 160 clks; color=0 in all blanking.
- mode=00, bench returns pixelIn=reqX[2:0] one tick after request → color equals x[2:0] in every visible pixel, aligned with de.
- mode 01→10 at line 100 → bars continue through frame; checkerboard (0 for x,y<16, 7 at x=16,y=0) from next frameStart.
- Override H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, CLK_DIV=1, H_POL=1; assert rst mid-line 2 → line period 12 clks, hSync high 2 clks; restart matches fresh reset.
